// File: rtl/md_scheduler.sv
// md_scheduler: HI/LO multiply/divide controller with fixed-latency busy window.
// Ports: clk, reset (sync, active-high), start, md_op[2:0], src_a, src_b,
//        d_uses_md, rd_sel -> rd_data[31:0], busy, stall.
//        With `define MD_FLUSH_EN a flush input aborts an in-flight op.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_uses_md,
    input  logic        rd_sel,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        stall
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_count;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_hi_pend;
    logic [31:0]   r_lo_pend;
    logic          r_pend_wr;

    logic          w_flush;
    logic          w_is_md;
    logic          w_is_mthi;
    logic          w_is_mtlo;
    logic          w_is_div;
    logic          w_signed;
    logic [63:0]   w_prod;
    logic [31:0]   w_da;
    logic [31:0]   w_db;
    logic [31:0]   w_db_nz;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic [31:0]   w_qf;
    logic [31:0]   w_rf;
    logic [31:0]   w_res_hi;
    logic [31:0]   w_res_lo;
    logic          w_res_wr;

`ifdef MD_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_is_md   = start & ~md_op[2];
    assign w_is_mthi = start & (md_op == 3'd4);
    assign w_is_mtlo = start & (md_op == 3'd5);
    assign w_is_div  = md_op[1];
    assign w_signed  = ~md_op[0];

    // Sign-extending to 64 bits makes the low 64 product bits correct
    // for both signed and unsigned operands.
    always_comb begin
        w_prod = '0;
        if (w_signed) begin
            w_prod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        end else begin
            w_prod = {32'b0, src_a} * {32'b0, src_b};
        end
    end

    // Signed division runs on magnitudes; the quotient takes the XOR of
    // the signs, the remainder the dividend's sign. This also yields
    // 0x80000000 / -1 = 0x80000000, rem 0 without a special case.
    assign w_da    = (w_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_db    = (w_signed & src_b[31]) ? (32'd0 - src_b) : src_b;
    assign w_db_nz = (w_db == 32'd0) ? 32'd1 : w_db;
    assign w_q     = w_da / w_db_nz;
    assign w_r     = w_da % w_db_nz;
    assign w_qf    = (w_signed & (src_a[31] ^ src_b[31])) ? (32'd0 - w_q) : w_q;
    assign w_rf    = (w_signed & src_a[31]) ? (32'd0 - w_r) : w_r;

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        w_res_wr = 1'b1;
        if (w_is_div) begin
            w_res_hi = w_rf;
            w_res_lo = w_qf;
            // Divide by zero still burns the window but leaves HI/LO alone
            w_res_wr = (src_b != 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_hi_pend <= '0;
            r_lo_pend <= '0;
            r_pend_wr <= 1'b0;
        end else if (w_flush) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_hi_pend <= '0;
            r_lo_pend <= '0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_md) begin
                        r_state   <= S_RUN;
                        r_count   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        r_hi_pend <= w_res_hi;
                        r_lo_pend <= w_res_lo;
                        r_pend_wr <= w_res_wr;
                    end else if (w_is_mthi) begin
                        r_hi <= src_a;
                    end else if (w_is_mtlo) begin
                        r_lo <= src_a;
                    end
                end
                default: begin
                    if (r_count == CW'(1)) begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        if (r_pend_wr) begin
                            r_hi <= r_hi_pend;
                            r_lo <= r_lo_pend;
                        end
                        r_pend_wr <= 1'b0;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
            endcase
        end
    end

    assign busy    = (r_state == S_RUN);
    assign stall   = d_uses_md & (busy | w_is_md);
    assign rd_data = rd_sel ? r_lo : r_hi;

endmodule
